// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives a req/ack instruction-memory port and
// presents IR / PC_OUT to decode, inserting bubbles while a branch is pending.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BR_RESOLVED,
    input  logic        BR_TAKEN,
    input  logic [15:0] BR_TARGET,
    output logic        IMEM_REQ,
    output logic [15:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [15:0] IMEM_DATA,
    output logic [15:0] IR,
    output logic [15:0] PC_OUT,
    output logic        IR_VALID,
    output logic [15:0] STALL_CYCLES
);

    typedef enum logic [0:0] {StFetch, StBrWait} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic        ir_valid_q, ir_valid_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] pc_inc;

    assign pc_inc       = pc_q + PC_INC;
    assign IMEM_REQ     = (state_q == StFetch) & ~STALL & ~RESET;
    assign IMEM_ADDR    = pc_q;
    assign IR           = ir_q;
    assign PC_OUT       = pc_out_q;
    assign IR_VALID     = ir_valid_q;
    assign STALL_CYCLES = stall_cycles_q;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = 16'h0000;
        ir_valid_d     = 1'b0;
        pc_out_d       = pc_out_q;
        stall_cycles_d = stall_cycles_q;
        unique case (state_q)
            StFetch: begin
                // A stall means decode holds a branch: drop any ack, nothing speculative.
                if (STALL) begin
                    state_d = StBrWait;
                end else if (IMEM_ACK) begin
                    ir_d       = IMEM_DATA;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_inc;
                    pc_out_d   = pc_inc;
                end
            end
            StBrWait: begin
                if (stall_cycles_q != 16'hFFFF) begin
                    stall_cycles_d = stall_cycles_q + 16'd1;
                end
                if (BR_RESOLVED && !STALL) begin
                    state_d = StFetch;
                    if (BR_TAKEN) begin
                        pc_d = {BR_TARGET[15:1], 1'b0};
                    end
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= StFetch;
            pc_q           <= RESET_PC;
            ir_q           <= 16'h0000;
            pc_out_q       <= 16'h0000;
            ir_valid_q     <= 1'b0;
            stall_cycles_q <= 16'h0000;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            pc_out_q       <= pc_out_d;
            ir_valid_q     <= ir_valid_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a scoreboard queue holds the expected IR/PC_OUT/IR_VALID
// for each cycle, pushed when stimulus is driven and popped after the clock edge.
module tb_if_stage;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] pc_out;
        logic        v;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        STALL = 1'b0;
    logic        BR_RESOLVED = 1'b0;
    logic        BR_TAKEN = 1'b0;
    logic [15:0] BR_TARGET = 16'h0000;
    logic        IMEM_ACK = 1'b0;
    logic [15:0] IMEM_DATA = 16'h0000;

    logic        IMEM_REQ, IR_VALID;
    logic [15:0] IMEM_ADDR, IR, PC_OUT, STALL_CYCLES;
    logic        w_req, w_valid;
    logic [15:0] w_addr, w_ir, w_pc_out, w_stall_cycles;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;

    if_stage dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .BR_RESOLVED(BR_RESOLVED),
        .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET), .IMEM_REQ(IMEM_REQ),
        .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA), .IR(IR),
        .PC_OUT(PC_OUT), .IR_VALID(IR_VALID), .STALL_CYCLES(STALL_CYCLES)
    );

    if_stage #(.RESET_PC(16'hFFFE), .PC_INC(16'd2)) dut_wrap (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .BR_RESOLVED(BR_RESOLVED),
        .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET), .IMEM_REQ(w_req),
        .IMEM_ADDR(w_addr), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA), .IR(w_ir),
        .PC_OUT(w_pc_out), .IR_VALID(w_valid), .STALL_CYCLES(w_stall_cycles)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; STALL = 1'b0; BR_RESOLVED = 1'b0; BR_TAKEN = 1'b0;
        IMEM_ACK = 1'b0; IMEM_DATA = 16'h0000;
        tick();
        tick();
        RESET = 1'b0;
        #1;
    endtask

    // Fetch n words from address 0 with ack every cycle; word at address a is 16'hA000|a
    // except the final one, which is last_word.
    task automatic fetch_from_zero(input int n, input logic [15:0] last_word);
        exp_t e;
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = 16'(2 * i);
            n_tests++;
            if (IMEM_ADDR !== a || IMEM_REQ !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_addr[%0d]: addr=%h req=%b, want addr=%h req=1",
                         i, IMEM_ADDR, IMEM_REQ, a);
            end
            IMEM_ACK  = 1'b1;
            IMEM_DATA = (i == n - 1) ? last_word : (16'hA000 | a);
            sb.push_back('{ir: IMEM_DATA, pc_out: a + 16'd2, v: 1'b1});
            tick();
            e = sb.pop_front();
            n_tests++;
            if (IR !== e.ir || PC_OUT !== e.pc_out || IR_VALID !== e.v) begin
                n_fail++;
                $display("FAIL seq_out[%0d]: ir=%h pc_out=%h v=%b, want ir=%h pc_out=%h v=%b",
                         i, IR, PC_OUT, IR_VALID, e.ir, e.pc_out, e.v);
            end
        end
        IMEM_ACK = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; IMEM_ACK = 1'b1; IMEM_DATA = 16'hDEAD;
        #1;
        n_tests++;
        if (IMEM_REQ !== 1'b0 || IR !== 16'h0 || PC_OUT !== 16'h0 || IR_VALID !== 1'b0 ||
            STALL_CYCLES !== 16'h0 || IMEM_ADDR !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: req=%b ir=%h pc_out=%h v=%b sc=%h addr=%h, want all 0",
                     IMEM_REQ, IR, PC_OUT, IR_VALID, STALL_CYCLES, IMEM_ADDR);
        end
        tick();
        n_tests++;
        if (IR !== 16'h0 || IR_VALID !== 1'b0 || IMEM_ADDR !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_ack_ignored: ir=%h v=%b addr=%h, want 0000/0/0000",
                     IR, IR_VALID, IMEM_ADDR);
        end
        do_reset();
    endtask

    task automatic test_fetch();
        logic [15:0] words [3];
        exp_t e;
        words[0] = 16'h1041; words[1] = 16'h1283; words[2] = 16'h6405;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (IMEM_ADDR !== 16'(2 * i) || IMEM_REQ !== 1'b1) begin
                n_fail++;
                $display("FAIL fetch_addr[%0d]: addr=%h req=%b, want addr=%h req=1",
                         i, IMEM_ADDR, IMEM_REQ, 16'(2 * i));
            end
            IMEM_ACK = 1'b1; IMEM_DATA = words[i];
            sb.push_back('{ir: words[i], pc_out: 16'(2 * (i + 1)), v: 1'b1});
            tick();
            e = sb.pop_front();
            n_tests++;
            if (IR !== e.ir || PC_OUT !== e.pc_out || IR_VALID !== e.v) begin
                n_fail++;
                $display("FAIL fetch_out[%0d]: ir=%h pc_out=%h v=%b, want ir=%h pc_out=%h v=%b",
                         i, IR, PC_OUT, IR_VALID, e.ir, e.pc_out, e.v);
            end
        end
        IMEM_ACK = 1'b0;
        n_tests++;
        if (IMEM_ADDR !== 16'h0006) begin
            n_fail++;
            $display("FAIL fetch_final_addr: addr=%h, want 0006", IMEM_ADDR);
        end
    endtask

    task automatic test_ack_wait();
        exp_t e;
        do_reset();
        fetch_from_zero(2, 16'h1283);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (IMEM_ADDR !== 16'h0004 || IMEM_REQ !== 1'b1) begin
                n_fail++;
                $display("FAIL wait_addr[%0d]: addr=%h req=%b, want 0004/1", i, IMEM_ADDR, IMEM_REQ);
            end
            IMEM_ACK  = (i == 3);
            IMEM_DATA = (i == 3) ? 16'h6405 : 16'hFFFF;
            if (i == 3) sb.push_back('{ir: 16'h6405, pc_out: 16'h0006, v: 1'b1});
            else        sb.push_back('{ir: 16'h0000, pc_out: 16'h0004, v: 1'b0});
            tick();
            e = sb.pop_front();
            n_tests++;
            if (IR !== e.ir || PC_OUT !== e.pc_out || IR_VALID !== e.v) begin
                n_fail++;
                $display("FAIL wait_out[%0d]: ir=%h pc_out=%h v=%b, want ir=%h pc_out=%h v=%b",
                         i, IR, PC_OUT, IR_VALID, e.ir, e.pc_out, e.v);
            end
        end
        IMEM_ACK = 1'b0;
    endtask

    task automatic test_branch(input logic taken);
        exp_t e;
        logic [15:0] want_addr;
        do_reset();
        fetch_from_zero(5, 16'h0E03);
        // Decode raises STALL for the BR while memory acks the next word.
        STALL = 1'b1; IMEM_ACK = 1'b1; IMEM_DATA = 16'hBEEF;
        #1;
        n_tests++;
        if (IMEM_REQ !== 1'b0 || IMEM_ADDR !== 16'h000A) begin
            n_fail++;
            $display("FAIL br_stall_req: req=%b addr=%h, want 0/000A", IMEM_REQ, IMEM_ADDR);
        end
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{ir: 16'h0000, pc_out: 16'h000A, v: 1'b0});
            if (i == 4) begin
                BR_RESOLVED = 1'b1; BR_TAKEN = taken; BR_TARGET = 16'h0021;
            end
            tick();
            STALL = 1'b0;
            BR_RESOLVED = 1'b0;
            e = sb.pop_front();
            n_tests++;
            if (IR !== e.ir || PC_OUT !== e.pc_out || IR_VALID !== e.v) begin
                n_fail++;
                $display("FAIL br_bubble[%0d]: ir=%h pc_out=%h v=%b, want ir=%h pc_out=%h v=%b",
                         i, IR, PC_OUT, IR_VALID, e.ir, e.pc_out, e.v);
            end
            if (i < 4) begin
                n_tests++;
                if (IMEM_REQ !== 1'b0) begin
                    n_fail++;
                    $display("FAIL br_wait_req[%0d]: req=%b, want 0", i, IMEM_REQ);
                end
            end
        end
        IMEM_ACK = 1'b0;
        want_addr = taken ? 16'h0020 : 16'h000A;
        n_tests++;
        if (IMEM_ADDR !== want_addr || IMEM_REQ !== 1'b1 || STALL_CYCLES !== 16'd4) begin
            n_fail++;
            $display("FAIL br_resume(taken=%b): addr=%h req=%b sc=%0d, want addr=%h req=1 sc=4",
                     taken, IMEM_ADDR, IMEM_REQ, STALL_CYCLES, want_addr);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] want [3];
        want[0] = 16'hFFFE; want[1] = 16'h0000; want[2] = 16'h0002;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (w_addr !== want[i] || w_req !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_addr[%0d]: addr=%h req=%b, want %h/1", i, w_addr, w_req, want[i]);
            end
            IMEM_ACK = 1'b1; IMEM_DATA = 16'h7000 + 16'(i);
            tick();
            if (i == 0) begin
                n_tests++;
                if (w_pc_out !== 16'h0000 || w_ir !== 16'h7000 || w_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_pc_out: pc_out=%h ir=%h v=%b, want 0000/7000/1",
                             w_pc_out, w_ir, w_valid);
                end
            end
        end
        IMEM_ACK = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        do_reset();
        fetch_from_zero(1, 16'h0E03);
        STALL = 1'b1;
        tick();
        STALL = 1'b0;
        tick();
        tick();
        #2;
        RESET = 1'b1; IMEM_ACK = 1'b1; IMEM_DATA = 16'hBAD0;
        BR_RESOLVED = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 16'h0040;
        #1;
        n_tests++;
        if (IR !== 16'h0 || IMEM_REQ !== 1'b0 || STALL_CYCLES !== 16'h0 || IR_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait_async: ir=%h req=%b sc=%h v=%b, want 0/0/0/0",
                     IR, IMEM_REQ, STALL_CYCLES, IR_VALID);
        end
        tick();
        BR_RESOLVED = 1'b0; IMEM_ACK = 1'b0;
        tick();
        RESET = 1'b0;
        #1;
        n_tests++;
        if (IMEM_ADDR !== 16'h0000 || IMEM_REQ !== 1'b1 || STALL_CYCLES !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_wait_release: addr=%h req=%b sc=%h, want 0000/1/0000",
                     IMEM_ADDR, IMEM_REQ, STALL_CYCLES);
        end
        IMEM_ACK = 1'b1; IMEM_DATA = 16'h1234;
        sb.push_back('{ir: 16'h1234, pc_out: 16'h0002, v: 1'b1});
        tick();
        IMEM_ACK = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (IR !== e.ir || PC_OUT !== e.pc_out || IR_VALID !== e.v) begin
            n_fail++;
            $display("FAIL rst_wait_refetch: ir=%h pc_out=%h v=%b, want ir=%h pc_out=%h v=%b",
                     IR, PC_OUT, IR_VALID, e.ir, e.pc_out, e.v);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_fetch();
        test_ack_wait();
        test_branch(1'b1);
        test_branch(1'b0);
        test_wrap();
        test_reset_in_wait();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage of the 5-stage pipeline. Drives IR and the incremented PC into the decode stage.
- Owns the PC and a request/acknowledge instruction-memory port.
- Inserts bubbles (IR = 16'h0000, a never-taken BR) while decode stalls on a branch.
- Redirects the PC when the branch resolves downstream.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- PC_INC, 2, byte increment per instruction (16-bit words, byte addressed).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- STALL  input  1  from decode; high while decode holds a non-NOP BR.
- BR_RESOLVED  input  1  one-cycle pulse from execute when the pending branch is decided.
- BR_TAKEN  input  1  qualifies BR_RESOLVED; 1 = redirect.
- BR_TARGET  input  16  redirect address; valid with BR_RESOLVED & BR_TAKEN.
- IMEM_REQ  output  1  fetch request.
- IMEM_ADDR  output  16  fetch address (= PC).
- IMEM_ACK  input  1  memory returns IMEM_DATA this cycle; ignored unless IMEM_REQ is high.
- IMEM_DATA  input  16  instruction word.
- IR  output  16  registered instruction to decode; 16'h0000 = bubble.
- PC_OUT  output  16  registered address of IR + PC_INC.
- IR_VALID  output  1  registered; 1 when IR holds a fetched instruction, not a bubble.
- STALL_CYCLES  output  16  saturating count of cycles spent in BR_WAIT.

Behaviour:
- Reset (asynchronous, immediate):
  - PC = RESET_PC.
  - IR = 0, PC_OUT = 0, IR_VALID = 0, STALL_CYCLES = 0.
  - State = FETCH.
  - IMEM_REQ forced low while RESET is high.
- States: FETCH, BR_WAIT.
- Combinational outputs:
  - IMEM_REQ = (state == FETCH) & ~STALL & ~RESET.
  - IMEM_ADDR = PC at all times.
- FETCH, IMEM_REQ & IMEM_ACK:
  - IR <= IMEM_DATA; PC_OUT <= PC + PC_INC; IR_VALID <= 1.
  - PC <= PC + PC_INC.
  - One instruction per cycle when memory acks every cycle; zero-latency acks give back-to-back fetch.
- FETCH, IMEM_REQ & ~IMEM_ACK:
  - IR <= 0; IR_VALID <= 0.
  - PC and IMEM_ADDR held stable until ack.
  - PC_OUT holds its previous value.
- FETCH, STALL high:
  - Decode latches the BR this cycle.
  - Any IMEM_ACK is ignored (no speculative fetch past a branch); PC unchanged.
  - IR <= 0; IR_VALID <= 0; next state = BR_WAIT.
  - The bubble drops STALL the following cycle.
- BR_WAIT:
  - IMEM_REQ = 0; IR <= 0; IR_VALID <= 0.
  - STALL_CYCLES increments, saturating at 16'hFFFF.
- BR_WAIT, BR_RESOLVED:
  - If BR_TAKEN, PC <= {BR_TARGET[15:1], 1'b0} (bit 0 forced to 0); otherwise PC unchanged, i.e. the instruction after the BR.
  - Next state = FETCH; the first request goes out the following cycle.
- BR_RESOLVED in FETCH is ignored; no PC change.
- STALL is low in BR_WAIT by construction. If STALL is high in BR_WAIT, remain in BR_WAIT.
- PC arithmetic is 16-bit modulo: 16'hFFFE + 2 = 16'h0000, no flag.
- RESET mid-BR_WAIT or mid-request: the outstanding request is abandoned and fetch restarts at RESET_PC. A late IMEM_ACK during RESET is ignored.
- PC_OUT is the address the decode-stage PC-relative offset adds to.

Test Plan:
- Reset, then memory acks every cycle with data 16'h1041, 16'h1283, 16'h6405 -> IR shows those words on consecutive cycles; PC_OUT = 2, 4, 6; IMEM_ADDR = 0, 2, 4, 6; IR_VALID = 1.
- Ack withheld 3 cycles at address 16'h0004 -> IMEM_ADDR stays 16'h0004; IR = 0 and IR_VALID = 0 for 3 cycles; then the ack's data appears with PC_OUT = 6.
- Fetch BR 16'h0E03 at 16'h0008, STALL asserted with a simultaneous ack of 16'hBEEF -> 16'hBEEF never reaches IR; IMEM_REQ low.
  - Hold 4 cycles, then BR_RESOLVED & BR_TAKEN with BR_TARGET = 16'h0021 -> next IMEM_ADDR = 16'h0020; STALL_CYCLES = 4.
- Same as above but BR_TAKEN = 0 -> fetch resumes at IMEM_ADDR = 16'h000A.
- RESET_PC = 16'hFFFE, ack every cycle -> IMEM_ADDR sequence FFFE, 0000, 0002; PC_OUT after the first fetch = 16'h0000.
- Assert RESET during BR_WAIT, with BR_RESOLVED pulsed while RESET is high -> IR = 0, IMEM_REQ = 0 during reset; after release IMEM_ADDR = RESET_PC, STALL_CYCLES = 0, pulse ignored.
